// File: rtl/echo_rr_arbiter.sv
// Round-robin arbiter sharing one Echo say/heard method pair between two requesters.
// An in-order tag FIFO records which requester owns each outstanding say so heards are steered back.
module echo_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         req0_say__ENA,
    input  logic [DATA_WIDTH-1:0]        req0_say_v,
    output logic                         req0_say__RDY,
    input  logic                         req1_say__ENA,
    input  logic [DATA_WIDTH-1:0]        req1_say_v,
    output logic                         req1_say__RDY,
    output logic                         echo_say__ENA,
    output logic [DATA_WIDTH-1:0]        echo_say_v,
    input  logic                         echo_say__RDY,
    input  logic                         echo_heard__ENA,
    input  logic [DATA_WIDTH-1:0]        echo_heard_v,
    output logic                         echo_heard__RDY,
    output logic                         req0_heard__ENA,
    output logic [DATA_WIDTH-1:0]        req0_heard_v,
    input  logic                         req0_heard__RDY,
    output logic                         req1_heard__ENA,
    output logic [DATA_WIDTH-1:0]        req1_heard_v,
    input  logic                         req1_heard__RDY,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic [CNT_WIDTH-1:0]         grant_count0,
    output logic [CNT_WIDTH-1:0]         grant_count1
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TAG_DEPTH);

    logic                 prio;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic [TAG_DEPTH-1:0] tag_mem;

    logic base;
    logic grant0;
    logic grant1;
    logic push;
    logic pop;
    logic head;
    logic empty;

    // Only the non-priority guard looks at the other requester's ENA, which keeps ENA->RDY acyclic.
    assign base          = echo_say__RDY & (occ != OCC_FULL);
    assign req0_say__RDY = base & (~prio | ~req1_say__ENA);
    assign req1_say__RDY = base & ( prio | ~req0_say__ENA);

    assign grant0 = req0_say__ENA & req0_say__RDY;
    assign grant1 = req1_say__ENA & req1_say__RDY;
    assign push   = grant0 | grant1;

    assign echo_say__ENA = req0_say__ENA | req1_say__ENA;
    assign echo_say_v    = req0_say__ENA ? req0_say_v :
                           req1_say__ENA ? req1_say_v : '0;

    assign empty           = (occ == '0);
    assign head            = tag_mem[rd_ptr];
    assign echo_heard__RDY = ~empty & (head ? req1_heard__RDY : req0_heard__RDY);
    assign pop             = echo_heard__ENA & echo_heard__RDY;

    assign req0_heard__ENA = echo_heard__ENA & ~head;
    assign req1_heard__ENA = echo_heard__ENA &  head;
    assign req0_heard_v    = echo_heard_v;
    assign req1_heard_v    = echo_heard_v;

    assign outstanding = occ;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prio         <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            grant_count0 <= '0;
            grant_count1 <= '0;
        end else begin
            if (grant0) begin
                prio         <= 1'b1;
                grant_count0 <= grant_count0 + 1'b1;
            end else if (grant1) begin
                prio         <= 1'b0;
                grant_count1 <= grant_count1 + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Tag storage is only read behind a valid occupancy, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push) tag_mem[wr_ptr] <= grant1;
    end

endmodule

// File: tb/tb_echo_rr_arbiter.sv
// Directed self-checking bench for echo_rr_arbiter; the bench plays both requesters and Echo.
module tb_echo_rr_arbiter;

    localparam int DW = 32;
    localparam int TD = 4;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          nRST = 1'b1;
    logic          req0_say__ENA, req1_say__ENA, echo_say__RDY, echo_heard__ENA;
    logic          req0_heard__RDY, req1_heard__RDY;
    logic [DW-1:0] req0_say_v, req1_say_v, echo_heard_v;
    logic          req0_say__RDY, req1_say__RDY, echo_say__ENA, echo_heard__RDY;
    logic          req0_heard__ENA, req1_heard__ENA;
    logic [DW-1:0] echo_say_v, req0_heard_v, req1_heard_v;
    logic [2:0]    outstanding;
    logic [CW-1:0] grant_count0, grant_count1;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 CLK = ~CLK;

    echo_rr_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0_say__ENA(req0_say__ENA), .req0_say_v(req0_say_v), .req0_say__RDY(req0_say__RDY),
        .req1_say__ENA(req1_say__ENA), .req1_say_v(req1_say_v), .req1_say__RDY(req1_say__RDY),
        .echo_say__ENA(echo_say__ENA), .echo_say_v(echo_say_v), .echo_say__RDY(echo_say__RDY),
        .echo_heard__ENA(echo_heard__ENA), .echo_heard_v(echo_heard_v), .echo_heard__RDY(echo_heard__RDY),
        .req0_heard__ENA(req0_heard__ENA), .req0_heard_v(req0_heard_v), .req0_heard__RDY(req0_heard__RDY),
        .req1_heard__ENA(req1_heard__ENA), .req1_heard_v(req1_heard_v), .req1_heard__RDY(req1_heard__RDY),
        .outstanding(outstanding), .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    // Callers may only invoke a method while its guard is high.
    always @(posedge CLK) begin
        if (nRST) begin
            assert (!(req0_say__ENA && !req0_say__RDY)) else $error("handshake violation req0 say");
            assert (!(req1_say__ENA && !req1_say__RDY)) else $error("handshake violation req1 say");
            assert (!(echo_heard__ENA && !echo_heard__RDY)) else $error("handshake violation echo heard");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_say__ENA = 0; req1_say__ENA = 0; req0_say_v = '0; req1_say_v = '0;
        echo_say__RDY = 1; echo_heard__ENA = 0; echo_heard_v = '0;
        req0_heard__RDY = 1; req1_heard__RDY = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        tick();
        nRST = 1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1;
        #2 nRST = 0;
        #2;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (grant_count0 !== 16'd0 || grant_count1 !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", grant_count0, grant_count1); end
        checks++; if (echo_heard__RDY !== 1'b0) begin errors++; $display("FAIL reset_heard_rdy: got %b want 0", echo_heard__RDY); end
        tick();
        nRST = 1;
        #1;
        checks++; if ({req0_say__RDY, req1_say__RDY} !== 2'b11) begin errors++; $display("FAIL reset_say_rdy: got %b want 11", {req0_say__RDY, req1_say__RDY}); end
    endtask

    task automatic test_single();
        do_reset();
        req0_say__ENA = 1; req0_say_v = 32'h11;
        #1;
        checks++; if (echo_say__ENA !== 1'b1 || echo_say_v !== 32'h11) begin errors++; $display("FAIL single_fwd: got %b/%h want 1/11", echo_say__ENA, echo_say_v); end
        tick();
        req0_say__ENA = 0;
        #1;
        checks++; if (outstanding !== 3'd1 || grant_count0 !== 16'd1) begin errors++; $display("FAIL single_state: got occ=%0d gc0=%0d want 1/1", outstanding, grant_count0); end
        // prio is now 1: req1 enabling must block req0's guard
        req1_say__ENA = 1;
        #1;
        checks++; if ({req0_say__RDY, req1_say__RDY} !== 2'b01) begin errors++; $display("FAIL single_prio: got %b want 01", {req0_say__RDY, req1_say__RDY}); end
        req1_say__ENA = 0;
        echo_heard__ENA = 1; echo_heard_v = 32'h12;
        #1;
        checks++; if ({req0_heard__ENA, req1_heard__ENA} !== 2'b10 || req0_heard_v !== 32'h12) begin errors++; $display("FAIL single_heard: got %b/%h want 10/12", {req0_heard__ENA, req1_heard__ENA}, req0_heard_v); end
        tick();
        echo_heard__ENA = 0;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_pop: got %0d want 0", outstanding); end
    endtask

    task automatic test_alternate();
        logic [DW-1:0] sent[6];
        int g, t;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            g = k % 2;
            req0_say__ENA = 1; req1_say__ENA = 1;
            req0_say_v = 32'hA0 + k; req1_say_v = 32'hB0 + k;
            #1;
            checks++; if ({req0_say__RDY, req1_say__RDY} !== (g ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_rdy[%0d]: got %b want %b", k, {req0_say__RDY, req1_say__RDY}, (g ? 2'b01 : 2'b10)); end
            if (g) req0_say__ENA = 0; else req1_say__ENA = 0;
            sent[k] = g ? 32'hB0 + k : 32'hA0 + k;
            if (k > 0) begin
                t = exp_q.pop_front();
                echo_heard__ENA = 1; echo_heard_v = sent[k-1] + 1;
            end
            #1;
            checks++; if (echo_say_v !== sent[k]) begin errors++; $display("FAIL alt_say_v[%0d]: got %h want %h", k, echo_say_v, sent[k]); end
            if (k > 0) begin
                checks++; if ({req0_heard__ENA, req1_heard__ENA} !== (t ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_route[%0d]: got %b want %b", k, {req0_heard__ENA, req1_heard__ENA}, (t ? 2'b01 : 2'b10)); end
            end
            exp_q.push_back(g);
            tick();
            req0_say__ENA = 0; req1_say__ENA = 0; echo_heard__ENA = 0;
            checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL alt_occ[%0d]: got %0d want 1", k, outstanding); end
        end
        t = exp_q.pop_front();
        echo_heard__ENA = 1; echo_heard_v = sent[5] + 1;
        #1;
        checks++; if ({req0_heard__ENA, req1_heard__ENA} !== 2'b01 || req1_heard_v !== 32'hB6) begin errors++; $display("FAIL alt_last: got %b/%h want 01/b6", {req0_heard__ENA, req1_heard__ENA}, req1_heard_v); end
        tick();
        echo_heard__ENA = 0;
        checks++; if (grant_count0 !== 16'd3 || grant_count1 !== 16'd3 || outstanding !== 3'd0) begin errors++; $display("FAIL alt_counts: got %0d/%0d occ=%0d want 3/3 occ=0", grant_count0, grant_count1, outstanding); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0_say__ENA = 1; req0_say_v = 32'h30 + k;
            tick();
        end
        req0_say__ENA = 0;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d want 4", outstanding); end
        checks++; if ({req0_say__RDY, req1_say__RDY} !== 2'b00) begin errors++; $display("FAIL full_rdy: got %b want 00", {req0_say__RDY, req1_say__RDY}); end
        echo_heard__ENA = 1; echo_heard_v = 32'h31;
        #1;
        checks++; if (req0_say__RDY !== 1'b0 || req0_heard__ENA !== 1'b1) begin errors++; $display("FAIL full_nobypass: got rdy=%b hen=%b want 0/1", req0_say__RDY, req0_heard__ENA); end
        tick();
        echo_heard__ENA = 0;
        #1;
        checks++; if (outstanding !== 3'd3 || req0_say__RDY !== 1'b1) begin errors++; $display("FAIL full_release: got occ=%0d rdy=%b want 3/1", outstanding, req0_say__RDY); end
    endtask

    task automatic test_stall();
        do_reset();
        req1_say__ENA = 1; req1_say_v = 32'h55;
        tick();
        req1_say__ENA = 0;
        req1_heard__RDY = 0; req0_heard__RDY = 1;
        #1;
        checks++; if (echo_heard__RDY !== 1'b0) begin errors++; $display("FAIL stall_rdy_low: got %b want 0", echo_heard__RDY); end
        tick();
        tick();
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL stall_hold: got %0d want 1", outstanding); end
        req1_heard__RDY = 1; req0_heard__RDY = 0;
        #1;
        checks++; if (echo_heard__RDY !== 1'b1) begin errors++; $display("FAIL stall_rdy_high: got %b want 1", echo_heard__RDY); end
        echo_heard__ENA = 1; echo_heard_v = 32'h56;
        #1;
        checks++; if ({req0_heard__ENA, req1_heard__ENA} !== 2'b01 || req1_heard_v !== 32'h56) begin errors++; $display("FAIL stall_deliver: got %b/%h want 01/56", {req0_heard__ENA, req1_heard__ENA}, req1_heard_v); end
        tick();
        echo_heard__ENA = 0; req0_heard__RDY = 1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL stall_pop: got %0d want 0", outstanding); end
    endtask

    task automatic test_push_pop_wrap();
        int pushes[5] = '{1, 1, 0, 1, 0};
        int t;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req0_say__ENA = 1; req0_say_v = 32'h70 + k;
            exp_q.push_back(0);
            tick();
        end
        req0_say__ENA = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                if (pushes[k] == 1) req1_say__ENA = 1; else req0_say__ENA = 1;
                req0_say_v = 32'h80 + k; req1_say_v = 32'h90 + k;
            end
            t = exp_q.pop_front();
            echo_heard__ENA = 1; echo_heard_v = 32'hC0 + k;
            #1;
            checks++; if ({req0_heard__ENA, req1_heard__ENA} !== (t ? 2'b01 : 2'b10)) begin errors++; $display("FAIL pp_route[%0d]: got %b want %b", k, {req0_heard__ENA, req1_heard__ENA}, (t ? 2'b01 : 2'b10)); end
            if (k < 5) exp_q.push_back(pushes[k]);
            tick();
            req0_say__ENA = 0; req1_say__ENA = 0; echo_heard__ENA = 0;
            checks++; if (outstanding !== ((k < 5) ? 3'd2 : 3'(6 - k))) begin errors++; $display("FAIL pp_occ[%0d]: got %0d want %0d", k, outstanding, ((k < 5) ? 2 : 6 - k)); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_say__ENA = 1; req0_say_v = 32'hE0 + k;
            tick();
        end
        req0_say__ENA = 0;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL ar_pre: got %0d want 3", outstanding); end
        #3 nRST = 0;
        #1;
        checks++; if (outstanding !== 3'd0 || grant_count0 !== 16'd0 || echo_heard__RDY !== 1'b0) begin errors++; $display("FAIL ar_async: got occ=%0d gc0=%0d hrdy=%b want 0/0/0", outstanding, grant_count0, echo_heard__RDY); end
        #1 nRST = 1;
        tick();
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ar_post: got %0d want 0", outstanding); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_stall();
        test_push_pop_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
